mci_mcu_rst_req_arb: RTL and testbench
======================================

# mci_mcu_rst_req_arb

Arbitrates MCU hitless-update reset requests from several independent requesters (e.g. Caliptra mailbox, SoC register, debug) into the single `mcu_rst_req` pulse consumed by the MCI boot sequencer. It then tracks the resulting MCU reset assertion and release, and returns a per-requester completion or timeout-error pulse. The block sits in MCI between the requester sources and the boot sequencer. Only one reset sequence is outstanding at a time.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters; legal range 2-8.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles allowed from request issue to MCU reset release; must be ≥ 2.
- `TO_W`, default `$clog2(TIMEOUT_CYCLES+1)`: width of the timeout counter. Derived; do not override.

Ports:
- `clk`, in, 1: MCI clock.
- `mci_rst`, in, 1: reset; asynchronous, active-high.
- `req_i`, in, NUM_REQ: level request per requester. Held until `done_o` or `err_o` for that requester.
- `seqr_ready_i`, in, 1: boot sequencer is waiting for an MCU reset request.
- `mcu_rst_b_i`, in, 1: MCU reset as driven by the boot sequencer; same clock domain; active-low.
- `timeout_clr_i`, in, 1: one-cycle clear of `timeout_sts_o`.
- `mcu_rst_req_o`, out, 1: one-cycle request pulse to the boot sequencer.
- `grant_o`, out, NUM_REQ: one-hot owner of the current sequence; all-zero when idle.
- `done_o`, out, NUM_REQ: one-hot one-cycle pulse on successful completion.
- `err_o`, out, NUM_REQ: one-hot one-cycle pulse on timeout.
- `busy_o`, out, 1: high when the FSM is not in IDLE.
- `timeout_sts_o`, out, 1: sticky flag; set on any timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RST, WAIT_REL, DONE, ERR.
- IDLE:
  - If any `req_i` bit is set and `seqr_ready_i`=1, the round-robin winner is latched into `grant_o` and the FSM moves to ISSUE.
  - If `seqr_ready_i`=0, stay in IDLE; requests are held off.
- ISSUE: `mcu_rst_req_o`=1 for exactly this cycle. Timeout counter is cleared. Next state is WAIT_RST.
- WAIT_RST: wait for `mcu_rst_b_i`=0, then go to WAIT_REL.
- WAIT_REL: wait for `mcu_rst_b_i`=1, then go to DONE.
- DONE:
  - `done_o[grant]`=1 for one cycle.
  - `grant_o` clears and the round-robin pointer updates.
  - Next state is IDLE.
- ERR:
  - `err_o[grant]`=1 for one cycle and `timeout_sts_o` is set.
  - `grant_o` clears and the round-robin pointer updates.
  - Next state is IDLE.
- Timeout counter (TO_W bits):
  - Increments every cycle in WAIT_RST and WAIT_REL.
  - When it equals TIMEOUT_CYCLES-1 and the state's exit condition is false, the next state is ERR.
  - The exit condition has priority over timeout in the same cycle.
  - The counter saturates and never wraps.
- Round-robin:
  - The pointer holds the index after the last granted requester; it resets to 0.
  - The search starts at the pointer and wraps modulo NUM_REQ.
  - The pointer advances only in DONE or ERR.
- `req_i` rules:
  - `req_i` is ignored for the granted requester until DONE or ERR.
  - A requester that deasserts before being granted is simply not selected.
  - A granted requester that still asserts `req_i` in the IDLE cycle after completion is treated as a new request.
- `timeout_sts_o`: set in ERR, cleared by `timeout_clr_i`. Set wins when both occur in the same cycle.
- Unknown or illegal state encoding: next state is IDLE and `grant_o` clears.

## Timing
- Reset values: all outputs 0, FSM in IDLE, pointer 0, counter 0.
- `mci_rst` asserted mid-sequence immediately forces the reset values. No `done_o` or `err_o` is generated for the aborted owner.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request to pulse: `req_i` and `seqr_ready_i` sampled high at edge T gives `grant_o` and `mcu_rst_req_o` high in cycle T+1. `mcu_rst_req_o` is low from T+2.
- `mcu_rst_b_i` sampled low at edge N in WAIT_RST gives WAIT_REL from N+1.
- `mcu_rst_b_i` sampled high at edge M in WAIT_REL gives `done_o` in cycle M+1.
- `grant_o` is zero from M+2.
- The earliest next `mcu_rst_req_o` is at M+3.
- Timeout: with no reset activity after ISSUE at cycle T+1, `err_o` is asserted in cycle T+2+TIMEOUT_CYCLES.
- `busy_o` is high from T+1 through the DONE or ERR cycle inclusive.

## Test plan
- Single request, NUM_REQ=3: `req_i`=3'b010, `seqr_ready_i`=1. Sequencer drops `mcu_rst_b_i` 5 cycles after the pulse and raises it 20 cycles later -> one `mcu_rst_req_o` pulse, `grant_o`=3'b010 throughout, one `done_o`=3'b010, `busy_o` low afterwards.
- Fairness: `req_i`=3'b111 held, each sequence completing normally -> grant order 0, 1, 2, 0; exactly one `done_o` per sequence.
- Timeout with TIMEOUT_CYCLES=16: `mcu_rst_b_i` stuck at 1 -> `err_o`=one-hot of owner in cycle 17 after ISSUE, `timeout_sts_o`=1. Then `timeout_clr_i` -> `timeout_sts_o`=0. The next request proceeds normally.
- Boundary: `mcu_rst_b_i` rises in the same cycle the counter hits TIMEOUT_CYCLES-1 -> `done_o` pulses, no `err_o`.
- Hold-off: `req_i`=3'b001 with `seqr_ready_i`=0 for 10 cycles -> no pulse and `busy_o`=0. `seqr_ready_i` rises -> pulse on the next cycle.
- Reset mid-WAIT_REL: assert `mci_rst` -> all outputs 0 immediately, no `done_o` or `err_o`. After release, a held request restarts at requester 0 priority.

Source files
------------

// File: rtl/mci_mcu_rst_req_arb.sv
// Round-robin arbiter for MCU hitless-update reset requests; issues one reset request
// pulse to the boot sequencer, tracks MCU reset assert/release, returns done or timeout.
module mci_mcu_rst_req_arb #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               mci_rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               seqr_ready_i,
  input  logic               mcu_rst_b_i,
  input  logic               timeout_clr_i,
  output logic               mcu_rst_req_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic [NUM_REQ-1:0] err_o,
  output logic               busy_o,
  output logic               timeout_sts_o
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RST = 3'd2,
    WAIT_REL = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   gidx_q;
  logic [TO_W-1:0]    cnt_q;
  logic               mcu_rst_req_q;
  logic               busy_q;
  logic               timeout_sts_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] err_q;

  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic [PTR_W-1:0]   ptr_d;
  logic               to_hit;

  // Search from the pointer, wrapping modulo NUM_REQ; first set request wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!win_vld && req_i[cand[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  assign ptr_d  = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
  assign to_hit = (cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge mci_rst) begin
    if (mci_rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gidx_q        <= '0;
      cnt_q         <= '0;
      mcu_rst_req_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_sts_q <= 1'b0;
      grant_q       <= '0;
      done_q        <= '0;
      err_q         <= '0;
    end else begin
      mcu_rst_req_q <= 1'b0;
      done_q        <= '0;
      err_q         <= '0;
      if (timeout_clr_i) begin
        timeout_sts_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (win_vld && seqr_ready_i) begin
            state_q       <= ISSUE;
            gidx_q        <= win_idx;
            grant_q       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            mcu_rst_req_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_RST;
        end
        WAIT_RST, WAIT_REL: begin
          if (cnt_q != TO_SAT) begin
            cnt_q <= cnt_q + TO_W'(1);
          end
          // The exit condition is checked before the timeout so a late edge still completes.
          if ((state_q == WAIT_RST) && !mcu_rst_b_i) begin
            state_q <= WAIT_REL;
          end else if ((state_q == WAIT_REL) && mcu_rst_b_i) begin
            state_q <= DONE;
            done_q  <= grant_q;
          end else if (to_hit) begin
            state_q       <= ERR;
            err_q         <= grant_q;
            timeout_sts_q <= 1'b1;
          end
        end
        DONE, ERR: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mcu_rst_req_o = mcu_rst_req_q;
  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign busy_o        = busy_q;
  assign timeout_sts_o = timeout_sts_q;

endmodule

// File: tb/tb_mci_mcu_rst_req_arb.sv
// Directed bench for mci_mcu_rst_req_arb: instance a has a long timeout, instance b uses 16 cycles.
module tb_mci_mcu_rst_req_arb;
  logic       clk = 1'b0;
  logic       mci_rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       ready = 1'b0;
  logic       rst_b = 1'b1;
  logic       clr = 1'b0;
  logic       use_b = 1'b0;

  logic       req_a, busy_a, sts_a, req_b, busy_b, sts_b;
  logic [2:0] grant_a, done_a, err_a, grant_b, done_b, err_b;
  logic       req_m, busy_m, sts_m;
  logic [2:0] grant_m, done_m, err_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mci_mcu_rst_req_arb #(.NUM_REQ(3), .TIMEOUT_CYCLES(64)) u_dut_a (
    .clk(clk), .mci_rst(mci_rst), .req_i(req), .seqr_ready_i(ready),
    .mcu_rst_b_i(rst_b), .timeout_clr_i(clr), .mcu_rst_req_o(req_a),
    .grant_o(grant_a), .done_o(done_a), .err_o(err_a), .busy_o(busy_a),
    .timeout_sts_o(sts_a)
  );

  mci_mcu_rst_req_arb #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) u_dut_b (
    .clk(clk), .mci_rst(mci_rst), .req_i(req), .seqr_ready_i(ready),
    .mcu_rst_b_i(rst_b), .timeout_clr_i(clr), .mcu_rst_req_o(req_b),
    .grant_o(grant_b), .done_o(done_b), .err_o(err_b), .busy_o(busy_b),
    .timeout_sts_o(sts_b)
  );

  always_comb begin
    req_m   = use_b ? req_b   : req_a;
    busy_m  = use_b ? busy_b  : busy_a;
    sts_m   = use_b ? sts_b   : sts_a;
    grant_m = use_b ? grant_b : grant_a;
    done_m  = use_b ? done_b  : done_a;
    err_m   = use_b ? err_b   : err_a;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the request pulse (cycle 0), drives mcu_rst_b low over [drop_c, rise_c),
  // and returns in the cycle the done/err pulse is seen.
  task automatic run_seq(input string tag, input logic [2:0] exp_gnt, input int exp_wait,
                         input int drop_c, input int rise_c, input bit exp_err,
                         input int exp_end, input bit keep_req);
    int w, end_c, npulse, gbad, nbad;
    logic [2:0] end_v;
    w = 0;
    while (req_m !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check({tag, "_wait"}, 32'(w), 32'(exp_wait));
    check({tag, "_grant"}, 32'(grant_m), 32'(exp_gnt));
    check({tag, "_busy"}, 32'(busy_m), 32'd1);
    end_c = -1; npulse = 0; gbad = 0; nbad = 0; end_v = 3'b000;
    for (int c = 0; c < 64; c++) begin
      if (c > 0 && req_m !== 1'b0) npulse++;
      if (grant_m !== exp_gnt) gbad++;
      if ((exp_err ? done_m : err_m) !== 3'b000) nbad++;
      if ((exp_err ? err_m : done_m) !== 3'b000) begin
        end_c = c;
        end_v = exp_err ? err_m : done_m;
      end
      rst_b = !(c >= drop_c && c < rise_c);
      if (end_c >= 0) break;
      tick();
    end
    check({tag, "_end_cycle"}, 32'(end_c), 32'(exp_end));
    check({tag, "_end_val"}, 32'(end_v), 32'(exp_gnt));
    check({tag, "_extra_pulse"}, 32'(npulse), 32'd0);
    check({tag, "_grant_held"}, 32'(gbad), 32'd0);
    check({tag, "_wrong_kind"}, 32'(nbad), 32'd0);
    check({tag, "_busy_end"}, 32'(busy_m), 32'd1);
    if (!keep_req) req = req & ~exp_gnt;
  endtask

  task automatic pulse_reset();
    mci_rst = 1'b1;
    tick();
    mci_rst = 1'b0;
  endtask

  initial begin
    int np, nb, w, bad;
    rst_b = 1'b1;
    tick();
    tick();
    check("rst_grant", 32'(grant_a), 32'd0);
    check("rst_req", 32'(req_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_sts", 32'(sts_a), 32'd0);
    mci_rst = 1'b0;

    // Hold-off: sequencer not ready.
    req = 3'b001; ready = 1'b0;
    np = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_m !== 1'b0) np++;
      if (busy_m !== 1'b0) nb++;
    end
    check("hold_pulses", 32'(np), 32'd0);
    check("hold_busy", 32'(nb), 32'd0);
    ready = 1'b1;
    run_seq("hold", 3'b001, 1, 2, 5, 1'b0, 6, 1'b0);

    // Single request, drop 5 after pulse, release 20 later.
    req = 3'b010;
    run_seq("single", 3'b010, 2, 5, 25, 1'b0, 26, 1'b0);
    tick();
    check("single_busy_after", 32'(busy_m), 32'd0);
    check("single_grant_after", 32'(grant_m), 32'd0);

    // Fairness from a fresh pointer.
    pulse_reset();
    req = 3'b111;
    run_seq("fair0", 3'b001, 1, 2, 5, 1'b0, 6, 1'b1);
    run_seq("fair1", 3'b010, 2, 2, 5, 1'b0, 6, 1'b1);
    run_seq("fair2", 3'b100, 2, 2, 5, 1'b0, 6, 1'b1);
    run_seq("fair3", 3'b001, 2, 2, 5, 1'b0, 6, 1'b1);

    // Reset in WAIT_REL; pointer now favours requester 1.
    w = 0;
    while (req_m !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    check("mid_grant", 32'(grant_m), 32'b010);
    rst_b = 1'b0;
    tick(); tick(); tick();
    check("mid_busy_before", 32'(busy_m), 32'd1);
    #2 mci_rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant_m), 32'd0);
    check("mid_rst_busy", 32'(busy_m), 32'd0);
    check("mid_rst_pulses", 32'({req_m, done_m, err_m, sts_m}), 32'd0);
    rst_b = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ((done_m | err_m) !== 3'b000) bad++;
    end
    check("mid_no_done_err", 32'(bad), 32'd0);
    mci_rst = 1'b0;
    run_seq("mid_restart", 3'b001, 1, 2, 4, 1'b0, 5, 1'b0);
    req = 3'b000;

    // Timeout with 16-cycle limit.
    use_b = 1'b1;
    tick();
    pulse_reset();
    req = 3'b001;
    run_seq("to", 3'b001, 1, 1000, 1000, 1'b1, 17, 1'b0);
    check("to_sts_err", 32'(sts_m), 32'd1);
    tick();
    check("to_sts_sticky", 32'(sts_m), 32'd1);
    check("to_idle_busy", 32'(busy_m), 32'd0);
    check("to_idle_grant", 32'(grant_m), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("to_sts_clr", 32'(sts_m), 32'd0);
    req = 3'b010;
    run_seq("to_next", 3'b010, 1, 2, 6, 1'b0, 7, 1'b0);

    // Release lands on the last counted cycle: completion wins.
    req = 3'b100;
    run_seq("bnd", 3'b100, 2, 3, 16, 1'b0, 17, 1'b0);
    check("bnd_sts", 32'(sts_m), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
